spi_flash_rd_master: RTL and testbench
======================================

Name: spi_flash_rd_master

Overview:
- SPI master that issues Winbond `03h` READ transactions to the serial NOR flash model on the SoC SPI bus, sitting directly upstream of it.
- Accepts word read requests from the SoC bus bridge, serialises command and address, deserialises the returned data, and returns one word per request.
- Drives SCK, chip-selects and MOSI; samples MISO. SCK is divided from clk.

Parameters:
- CLK_DIV, 2, SCK half-period in clk cycles; legal range ≥1.
- SS_NUM, 2, width of the chip-select bus.
- FLASH_SS, 0, index of the select line driven low for flash transactions.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- req_valid  in  1  read request valid
- req_ready  out  1  high only in IDLE
- req_addr  in  24  flash byte address; bits [1:0] ignored and sent as 0
- resp_valid  out  1  read data valid
- resp_ready  in  1  consumer accepts data
- resp_data  out  32  read word; 64 with SPI_FLASH_RD64_EN
- spi_sck  out  1  serial clock, idle low
- spi_ss  out  SS_NUM  active-low selects; all ones when idle
- spi_mosi  out  1  master out
- spi_miso  in  1  master in

Behaviour:
- Reset values:
  - spi_ss = all ones, spi_sck = 0, spi_mosi = 0.
  - resp_valid = 0, resp_data = 0, state = IDLE.
  - No request is accepted while reset is high.
- FSM states: IDLE → SETUP → SHIFT → HOLD → RESP → IDLE.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready, latch the frame {8'h03, req_addr[23:2], 2'b00} into the TX shift register and go to SETUP.
- SETUP:
  - spi_ss[FLASH_SS] = 0, SCK low, MOSI = TX bit 31, for CLK_DIV cycles. Then go to SHIFT.
- SHIFT covers NBIT SCK cycles, numbered 0..NBIT-1 (NBIT = 63, or 95 with RD64):
  - Each SCK cycle is CLK_DIV cycles low followed by CLK_DIV cycles high.
  - Cycle k, for k < 32, presents TX bit 31-k on MOSI while SCK is low.
  - MOSI = 0 for k ≥ 32.
  - MOSI changes only in the clk cycle in which SCK falls, or at SHIFT entry.
  - Sampling: in the clk cycle where SCK goes high→low in SCK cycles 31..NBIT-1, shift spi_miso into RX LSB-first-in. The slave updates MISO on SCK rising edges, and its first data bit is valid after rising edge 32.
  - After the last falling edge, go to HOLD.
- HOLD:
  - SCK low, ss still asserted, for CLK_DIV cycles.
  - Then deassert ss (all ones) and go to RESP.
- RESP:
  - resp_valid = 1.
  - resp_data = byte-swapped RX, so the first received byte (address A) is resp_data[7:0] and byte A+3 is [31:24], little-endian.
  - resp_data is held stable until resp_ready. The handshake returns to IDLE.
  - ss remains high for at least one clk cycle between transactions; the slave resets on ss high.
- Latency: with resp_ready tied high and CLK_DIV = 2, resp_valid rises exactly 128*CLK_DIV + 1 cycles after the accepting edge. That is (1 + NBIT*2 + 1)*CLK_DIV + 1 = 257 cycles.
- Back-pressure: while in RESP, req_ready = 0; requests wait.
- Reset mid-transaction: ss goes high immediately (asynchronous), all in-flight state is discarded, and no response is produced.
- resp_ready high outside RESP has no effect.

Optional Feature:
- SPI_FLASH_RD64_EN:
  - When defined: NBIT = 95 and resp_data is 64 bits, holding 8 bytes little-endian starting at req_addr & ~3.
  - When undefined: 32-bit reads, NBIT = 63.
  - Latency scales to (2 + 2*NBIT)*CLK_DIV + 1.

Decomposition:
- Shared package spi_flash_pkg holds:
  - the state enum (IDLE, SETUP, SHIFT, HOLD, RESP);
  - the constants FLASH_CMD_READ = 8'h03, CMD_BITS = 8, ADDR_BITS = 24.
- One natural sub-module, spi_sck_gen: the CLK_DIV counter producing rise/fall strobes and spi_sck, enabled by the FSM.

Test Plan:
- Flash image word at 0x000000 = 0x00100073, CLK_DIV = 2, read 0x000000 → MOSI stream 0x03,0x00,0x00,0x00; resp_data = 0x00100073; resp_valid at cycle 257.
- Read 0x000007 → address sent as 0x000004; resp_data = the little-endian word at bytes 4..7.
- Hold resp_ready low for 20 cycles with a second req_valid pending → resp_data stable, req_ready = 0, ss high; the second transaction starts after the handshake.
- Assert reset at SHIFT SCK cycle 20 → spi_ss = 2'b11 in the same cycle, no resp_valid; the next read of 0x000010 returns the correct word.
- CLK_DIV = 1, back-to-back reads 0x0, 0x4, 0x8 → three correct words; ss high ≥1 cycle between frames; each transaction is 129 cycles.
- With SPI_FLASH_RD64_EN, read 0x000000 → 64-bit little-endian doubleword, 95 SCK pulses counted.

Source files
------------

// File: rtl/spi_flash_pkg.sv
// Shared state encoding, command constants and read width for the SPI flash read master.
// Defining SPI_FLASH_RD64_EN widens each read to 64 bits (8 bytes per request).
package spi_flash_pkg;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, RESP} state_t;

    localparam logic [7:0] FLASH_CMD_READ = 8'h03;
    localparam int         CMD_BITS       = 8;
    localparam int         ADDR_BITS      = 24;
    localparam int         FRAME_BITS     = CMD_BITS + ADDR_BITS;

`ifdef SPI_FLASH_RD64_EN
    localparam int DATA_W = 64;
`else
    localparam int DATA_W = 32;
`endif

    // One SCK cycle is shared: the slave drives data bit 0 after the last address rise.
    localparam int NBIT   = FRAME_BITS + DATA_W - 1;
    localparam int BIT_CW = $clog2(NBIT + 1);

    // First received byte lands in the lowest byte lane (little-endian word).
    function automatic logic [DATA_W-1:0] byte_swap(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < DATA_W / 8; i++) begin
            r[8*i +: 8] = d[DATA_W-8-8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/spi_flash_rd_master_sck_gen.sv
// SCK divider: CLK_DIV clk cycles per half period, idle low while disabled.
// o_rise/o_fall are high in the clk cycle whose closing edge moves SCK up/down.
module spi_sck_gen
    import spi_flash_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    output logic o_sck,
    output logic o_rise,
    output logic o_fall
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_sck;
    logic          w_tc;

    assign w_tc   = (r_cnt == CW'(CLK_DIV - 1));
    assign o_sck  = r_sck;
    assign o_rise = i_en & w_tc & ~r_sck;
    assign o_fall = i_en & w_tc & r_sck;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_sck <= 1'b0;
        end else if (!i_en) begin
            r_cnt <= '0;
            r_sck <= 1'b0;
        end else if (w_tc) begin
            r_cnt <= '0;
            r_sck <= ~r_sck;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/spi_flash_rd_master.sv
// Issues one 03h READ per request and returns a little-endian word; SPI_FLASH_RD64_EN selects 64-bit reads.
// Response after (2 + 2*NBIT)*CLK_DIV + 1 clk; req_ready is low from acceptance until the response handshake.
module spi_flash_rd_master
    import spi_flash_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int SS_NUM   = 2,
    parameter int FLASH_SS = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_BITS-1:0] req_addr,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [DATA_W-1:0]    resp_data,
    output logic                 spi_sck,
    output logic [SS_NUM-1:0]    spi_ss,
    output logic                 spi_mosi,
    input  logic                 spi_miso
);

    localparam int DCW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [SS_NUM-1:0] SS_SEL = ~(SS_NUM'(1) << FLASH_SS);

    state_t                r_state;
    logic [FRAME_BITS-1:0] r_tx;
    logic [DATA_W-1:0]     r_rx;
    logic [SS_NUM-1:0]     r_ss;
    logic [DCW-1:0]        r_div_cnt;
    logic [BIT_CW-1:0]     r_bit_cnt;
    logic                  r_resp_valid;
    logic [DATA_W-1:0]     r_resp_data;

    logic w_sck_en;
    logic w_rise;
    logic w_fall;
    logic w_div_tc;

    assign w_sck_en   = (r_state == SHIFT);
    assign w_div_tc   = (r_div_cnt == DCW'(CLK_DIV - 1));
    assign req_ready  = (r_state == IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign spi_ss     = r_ss;
    // MOSI is the top of the TX register; it only moves when the register shifts.
    assign spi_mosi   = r_tx[FRAME_BITS-1];

    spi_sck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_gen (
        .clk    (clk),
        .reset  (reset),
        .i_en   (w_sck_en),
        .o_sck  (spi_sck),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_tx         <= '0;
            r_rx         <= '0;
            r_ss         <= '1;
            r_div_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_tx      <= {FLASH_CMD_READ, req_addr & ~ADDR_BITS'(3)};
                        r_ss      <= SS_SEL;
                        r_div_cnt <= '0;
                        r_bit_cnt <= '0;
                        r_state   <= SETUP;
                    end
                end
                SETUP: begin
                    r_div_cnt <= w_div_tc ? '0 : r_div_cnt + DCW'(1);
                    if (w_div_tc) r_state <= SHIFT;
                end
                SHIFT: begin
                    // r_bit_cnt counts rising edges, so at the fall of SCK cycle k it holds k+1.
                    if (w_rise) r_bit_cnt <= r_bit_cnt + BIT_CW'(1);
                    if (w_fall) begin
                        r_tx <= {r_tx[FRAME_BITS-2:0], 1'b0};
                        if (r_bit_cnt >= BIT_CW'(FRAME_BITS)) begin
                            r_rx <= {r_rx[DATA_W-2:0], spi_miso};
                        end
                        if (r_bit_cnt == BIT_CW'(NBIT)) begin
                            r_div_cnt <= '0;
                            r_state   <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    r_div_cnt <= w_div_tc ? '0 : r_div_cnt + DCW'(1);
                    if (w_div_tc) begin
                        r_ss    <= '1;
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    if (!r_resp_valid) begin
                        r_resp_valid <= 1'b1;
                        r_resp_data  <= byte_swap(r_rx);
                    end else if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_rd_master.sv
// Two masters (CLK_DIV 2 and 1), each on its own behavioural 03h flash slave over a shared byte image.
`timescale 1ns/1ps
module tb_spi_flash_rd_master;
    import spi_flash_pkg::*;

    localparam int DW   = DATA_W;
    localparam int NB   = NBIT;
    localparam int LAT0 = (2 + 2 * NB) * 2 + 1;
    localparam int LAT1 = (2 + 2 * NB) * 1 + 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          req_valid  [2];
    logic          req_ready  [2];
    logic [23:0]   req_addr   [2];
    logic          resp_valid [2];
    logic          resp_ready [2];
    logic [DW-1:0] resp_data  [2];
    logic          sck        [2];
    logic [1:0]    ss         [2];
    logic          mosi       [2];

    logic [31:0] last_frame  [2];
    int          last_pulses [2];
    int          cur_cnt     [2];
    int          mosi_viol   [2];

    logic [7:0] mem [256];

    int checks   = 0;
    int failures = 0;

    for (genvar g = 0; g < 2; g++) begin : g_bus
        logic        s_miso   = 1'b0;
        int          s_cnt    = 0;
        int          s_pulses = 0;
        int          s_viol   = 0;
        logic [31:0] s_frm    = '0;
        logic [31:0] s_last   = '0;
        logic        p_mosi   = 1'b0;
        logic        p_sck    = 1'b0;
        logic        p_sel    = 1'b0;

        spi_flash_rd_master #(
            .CLK_DIV  (g == 0 ? 2 : 1),
            .SS_NUM   (2),
            .FLASH_SS (0)
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_addr   (req_addr[g]),
            .resp_valid (resp_valid[g]),
            .resp_ready (resp_ready[g]),
            .resp_data  (resp_data[g]),
            .spi_sck    (sck[g]),
            .spi_ss     (ss[g]),
            .spi_mosi   (mosi[g]),
            .spi_miso   (s_miso)
        );

        // Flash: capture 32 bits on rising edges, then drive data MSB-first from rise 32 on.
        always @(posedge sck[g] or posedge ss[g][0]) begin : slave
            int idx;
            if (ss[g][0]) begin
                s_pulses = s_cnt;
                s_cnt    = 0;
                s_miso   = 1'b0;
            end else begin
                if (s_cnt < 32) s_frm = {s_frm[30:0], mosi[g]};
                s_cnt = s_cnt + 1;
                if (s_cnt == 32) s_last = s_frm;
                if (s_cnt >= 32) begin
                    idx    = s_cnt - 32;
                    s_miso = mem[(int'(s_frm[7:0]) + idx / 8) % 256][7 - idx % 8];
                end
            end
        end

        always @(negedge clk) begin
            if (p_sel && !ss[g][0] && (mosi[g] !== p_mosi) && !(p_sck && !sck[g])) s_viol = s_viol + 1;
            p_mosi = mosi[g];
            p_sck  = sck[g];
            p_sel  = (ss[g][0] === 1'b0);
        end

        assign last_frame[g]  = s_last;
        assign last_pulses[g] = s_pulses;
        assign cur_cnt[g]     = s_cnt;
        assign mosi_viol[g]   = s_viol;
    end

    function automatic logic [DW-1:0] exp_word(input logic [23:0] a);
        logic [DW-1:0] w;
        int base;
        w    = '0;
        base = int'({a[7:2], 2'b00});
        for (int i = 0; i < DW / 8; i++) w[8*i +: 8] = mem[(base + i) % 256];
        return w;
    endfunction

    function automatic logic [31:0] exp_frame(input logic [23:0] a);
        return {8'h03, a[23:2], 2'b00};
    endfunction

    task automatic start_req(input int d, input logic [23:0] a, output int waited);
        waited       = 0;
        req_valid[d] = 1'b1;
        req_addr[d]  = a;
        while (req_ready[d] !== 1'b1 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
    endtask

    task automatic wait_resp(input int d, output int lat);
        lat = 0;
        while (resp_valid[d] !== 1'b1 && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic ack(input int d);
        resp_ready[d] = 1'b1;
        @(negedge clk);
        resp_ready[d] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d]  = 1'b1;
            req_addr[d]   = 24'h0;
            resp_ready[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        checks++; if (ss[0] !== 2'b11) begin failures++; $display("FAIL reset_ss got=%b exp=11", ss[0]); end
        checks++; if (sck[0] !== 1'b0) begin failures++; $display("FAIL reset_sck got=%b exp=0", sck[0]); end
        checks++; if (mosi[0] !== 1'b0) begin failures++; $display("FAIL reset_mosi got=%b exp=0", mosi[0]); end
        checks++; if (resp_valid[0] !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid[0]); end
        checks++; if (resp_data[0] !== '0) begin failures++; $display("FAIL reset_resp_data got=%h exp=0", resp_data[0]); end
        checks++; if (ss[1] !== 2'b11) begin failures++; $display("FAIL reset_no_accept got=%b exp=11", ss[1]); end
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        reset        = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (req_ready[0] !== 1'b1) begin failures++; $display("FAIL idle_req_ready got=%b exp=1", req_ready[0]); end
        checks++; if (ss[0] !== 2'b11) begin failures++; $display("FAIL idle_ss got=%b exp=11", ss[0]); end
    endtask

    task automatic test_read(input int d, input logic [23:0] a, input string nm);
        int w;
        int lat;
        start_req(d, a, w);
        wait_resp(d, lat);
        checks++; if (lat != (d == 0 ? LAT0 : LAT1)) begin failures++; $display("FAIL %s_latency got=%0d exp=%0d", nm, lat, d == 0 ? LAT0 : LAT1); end
        checks++; if (resp_data[d] !== exp_word(a)) begin failures++; $display("FAIL %s_data got=%h exp=%h", nm, resp_data[d], exp_word(a)); end
        checks++; if (last_frame[d] !== exp_frame(a)) begin failures++; $display("FAIL %s_mosi_frame got=%h exp=%h", nm, last_frame[d], exp_frame(a)); end
        checks++; if (last_pulses[d] != NB) begin failures++; $display("FAIL %s_sck_pulses got=%0d exp=%0d", nm, last_pulses[d], NB); end
        checks++; if (ss[d] !== 2'b11) begin failures++; $display("FAIL %s_ss_in_resp got=%b exp=11", nm, ss[d]); end
        ack(d);
    endtask

    task automatic test_backpressure();
        int w;
        int lat;
        int n_unstable = 0;
        int n_ready    = 0;
        int n_ss       = 0;
        logic [DW-1:0] held;
        start_req(0, 24'h000020, w);
        wait_resp(0, lat);
        held         = resp_data[0];
        req_valid[0] = 1'b1;
        req_addr[0]  = 24'h000040;
        repeat (20) begin
            @(negedge clk);
            if (resp_data[0] !== held || resp_valid[0] !== 1'b1) n_unstable++;
            if (req_ready[0] !== 1'b0) n_ready++;
            if (ss[0] !== 2'b11) n_ss++;
        end
        checks++; if (held !== exp_word(24'h20)) begin failures++; $display("FAIL bp_data got=%h exp=%h", held, exp_word(24'h20)); end
        checks++; if (n_unstable != 0) begin failures++; $display("FAIL bp_stable got=%0d exp=0", n_unstable); end
        checks++; if (n_ready != 0) begin failures++; $display("FAIL bp_req_ready got=%0d exp=0", n_ready); end
        checks++; if (n_ss != 0) begin failures++; $display("FAIL bp_ss got=%0d exp=0", n_ss); end
        ack(0);
        start_req(0, 24'h000040, w);
        checks++; if (w != 0) begin failures++; $display("FAIL bp_second_start got=%0d exp=0", w); end
        wait_resp(0, lat);
        checks++; if (resp_data[0] !== exp_word(24'h40)) begin failures++; $display("FAIL bp_second_data got=%h exp=%h", resp_data[0], exp_word(24'h40)); end
        ack(0);
    endtask

    task automatic test_reset_mid();
        int w;
        int n    = 0;
        int seen = 0;
        start_req(0, 24'h000044, w);
        while (cur_cnt[0] < 21 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        reset = 1'b1;
        #1;
        checks++; if (ss[0] !== 2'b11) begin failures++; $display("FAIL midreset_ss got=%b exp=11", ss[0]); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (600) begin
            @(negedge clk);
            if (resp_valid[0] === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL midreset_no_resp got=%0d exp=0", seen); end
        test_read(0, 24'h000010, "after_reset");
    endtask

    task automatic test_random();
        logic [23:0] a;
        for (int i = 0; i < 4; i++) begin
            a = 24'($urandom);
            test_read(0, a, "random");
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) test_read(1, 24'(4 * i), "b2b");
        checks++; if (mosi_viol[0] != 0 || mosi_viol[1] != 0) begin failures++; $display("FAIL mosi_change_off_fall got=%0d/%0d exp=0/0", mosi_viol[0], mosi_viol[1]); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h73;
        mem[1] = 8'h00;
        mem[2] = 8'h10;
        mem[3] = 8'h00;
        test_reset();
        test_read(0, 24'h000000, "first_read");
        checks++; if (DW == 32 && resp_data[0] !== DW'(32'h00100073)) begin failures++; $display("FAIL first_word got=%h exp=00100073", resp_data[0]); end
        test_read(0, 24'h000007, "align");
        test_backpressure();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
